// File: rtl/fpu_pipe_arbiter.sv
// Round-robin front end for a shared fixed-latency FPU pipe: grants one requester per advance,
// tracks owner/valid alongside the datapath, and stalls the whole pipe on head backpressure.
module fpu_pipe_arbiter #(
    parameter int STAGES = 6,
    parameter int WIDTH  = 32,
    parameter int NREQ   = 4,
    localparam int IDW   = $clog2(NREQ),
    localparam int CW    = $clog2(STAGES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*WIDTH-1:0]  req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   pipe_en,
    output logic [WIDTH-1:0]       pipe_in_data,
    input  logic [WIDTH-1:0]       pipe_out_data,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [WIDTH-1:0]       rsp_data,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [CW-1:0]          inflight,
    output logic                   busy
);

    logic [STAGES-1:0] vld_p;
    logic [IDW-1:0]    id_p [STAGES];
    logic [IDW-1:0]    rr_ptr;
    logic              stall;
    logic              advance;
    logic              found;
    logic [IDW-1:0]    winner;
    logic [NREQ-1:0]   grant;

    // (base + off) mod NREQ, valid because both operands are below NREQ
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    assign stall   = vld_p[STAGES-1] & ~rsp_ready[id_p[STAGES-1]];
    assign advance = ~stall | flush;
    assign pipe_en = advance;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[wrap_idx(rr_ptr, k)]) begin
                found  = 1'b1;
                winner = wrap_idx(rr_ptr, k);
            end
        end
        grant = found ? (NREQ'(1) << winner) : '0;
    end

    // Nothing is accepted during reset so no request is silently lost
    assign req_ready    = grant & {NREQ{advance & ~flush & ~rst}};
    assign pipe_in_data = found ? WIDTH'(req_data >> (int'(winner) * WIDTH)) : '0;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = vld_p[STAGES-1] & (id_p[STAGES-1] == IDW'(i));
        end
    end

    assign rsp_data = pipe_out_data;

    // Shadow chain: shifts in lockstep with the datapath enable
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p  <= '0;
            rr_ptr <= '0;
            for (int k = 0; k < STAGES; k++) begin
                id_p[k] <= '0;
            end
        end else if (advance) begin
            vld_p[0] <= ~flush & found;
            id_p[0]  <= winner;
            for (int k = 1; k < STAGES; k++) begin
                vld_p[k] <= ~flush & vld_p[k-1];
                id_p[k]  <= id_p[k-1];
            end
            if (!flush && found) begin
                rr_ptr <= wrap_idx(winner, 1);
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k < STAGES; k++) begin
            inflight = inflight + CW'(vld_p[k]);
        end
    end

    assign busy = |vld_p;

endmodule
